// File: rtl/pc_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// pc_fetch_ctrl
//   Owns the program counter and sequences the instruction-fetch handshake
//   between the core and instruction memory. At most one fetch is outstanding.
//   A redirect (branch/jump) replaces the PC, and the response of a fetch that
//   is already in flight is dropped. A delivered instruction is held while the
//   staller asserts stall_i.
//
// Ports
//   clk               clock, all state updates on the rising edge
//   rst               asynchronous, active-high reset
//   stall_i           downstream cannot accept the held instruction
//   redirect_valid_i  branch/jump taken this cycle
//   redirect_pc_i     redirect target (bits [1:0] forced to zero)
//   fetch_req_o       fetch request to instruction memory
//   fetch_addr_o      fetch address (always equals pc_o)
//   fetch_gnt_i       memory accepted the request (req & gnt = accept)
//   fetch_rvalid_i    response valid, one per accepted request
//   fetch_rdata_i     instruction data of the response
//   inst_valid_o      inst_o / inst_pc_o hold a valid instruction
//   inst_o            delivered instruction
//   inst_pc_o         address of inst_o
//   pc_o              address of the next instruction to fetch
// -----------------------------------------------------------------------------
module pc_fetch_ctrl #(
    parameter int unsigned            ADDR_WIDTH = 32,
    parameter int unsigned            INST_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0]  RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall_i,
    input  logic                  redirect_valid_i,
    input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
    output logic                  fetch_req_o,
    output logic [ADDR_WIDTH-1:0] fetch_addr_o,
    input  logic                  fetch_gnt_i,
    input  logic                  fetch_rvalid_i,
    input  logic [INST_WIDTH-1:0] fetch_rdata_i,
    output logic                  inst_valid_o,
    output logic [INST_WIDTH-1:0] inst_o,
    output logic [ADDR_WIDTH-1:0] inst_pc_o,
    output logic [ADDR_WIDTH-1:0] pc_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        VALID = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [INST_WIDTH-1:0] inst_q, inst_d;
    logic [ADDR_WIDTH-1:0] inst_pc_q, inst_pc_d;
    logic                  inst_valid_q, inst_valid_d;
    logic                  discard_q, discard_d;

    logic [ADDR_WIDTH-1:0] redirect_target;

    // Targets are word aligned; the low two bits of the request are dropped.
    assign redirect_target = {redirect_pc_i[ADDR_WIDTH-1:2], 2'b00};

    // NOTE: every register, including the instruction holding registers, has a
    // reset value so that the outputs are deterministic straight out of reset.
    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from the values computed in the combinational block.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            inst_q       <= '0;
            inst_pc_q    <= '0;
            inst_valid_q <= 1'b0;
            discard_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            inst_valid_q <= inst_valid_d;
            discard_q    <= discard_d;
        end
    end

    always_comb begin
        // NOTE: every signal gets a hold-value default first so that no path
        // through the case statement leaves it unassigned (no latches).
        state_d      = state_q;
        pc_d         = pc_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        inst_valid_d = inst_valid_q;
        discard_d    = discard_q;

        // A redirect overrides the sequential PC and invalidates the held
        // instruction in every state.
        if (redirect_valid_i) begin
            pc_d         = redirect_target;
            inst_valid_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                state_d = REQ;
            end

            REQ: begin
                if (fetch_gnt_i) begin
                    state_d = WAIT;
                    // The accepted fetch targets the old PC; drop its response.
                    if (redirect_valid_i) discard_d = 1'b1;
                end
            end

            WAIT: begin
                if (fetch_rvalid_i) begin
                    if (discard_q || redirect_valid_i) begin
                        // Stale response: drop it and fetch from the current PC.
                        discard_d = 1'b0;
                        state_d   = REQ;
                    end else begin
                        inst_d       = fetch_rdata_i;
                        inst_pc_d    = pc_q;
                        pc_d         = pc_q + ADDR_WIDTH'(4);
                        inst_valid_d = 1'b1;
                        state_d      = VALID;
                    end
                end else if (redirect_valid_i) begin
                    discard_d = 1'b1;
                end
            end

            VALID: begin
                if (redirect_valid_i || !stall_i) begin
                    inst_valid_d = 1'b0;
                    state_d      = REQ;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    assign fetch_req_o  = (state_q == REQ);
    assign fetch_addr_o = pc_q;
    assign pc_o         = pc_q;
    assign inst_o       = inst_q;
    assign inst_pc_o    = inst_pc_q;
    assign inst_valid_o = inst_valid_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pc_fetch_ctrl
//   Directed bench for pc_fetch_ctrl. Inputs change on the falling edge and
//   outputs are sampled on the falling edge, half a cycle after the rising edge
//   that updated them. Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_pc_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i;
    logic        redirect_valid_i;
    logic [31:0] redirect_pc_i;
    logic        fetch_req_o;
    logic [31:0] fetch_addr_o;
    logic        fetch_gnt_i;
    logic        fetch_rvalid_i;
    logic [31:0] fetch_rdata_i;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic [31:0] pc_o;

    int n_checks = 0;
    int n_fail   = 0;

    pc_fetch_ctrl #(
        .ADDR_WIDTH (32),
        .INST_WIDTH (32),
        .RESET_PC   (32'h0)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .stall_i          (stall_i),
        .redirect_valid_i (redirect_valid_i),
        .redirect_pc_i    (redirect_pc_i),
        .fetch_req_o      (fetch_req_o),
        .fetch_addr_o     (fetch_addr_o),
        .fetch_gnt_i      (fetch_gnt_i),
        .fetch_rvalid_i   (fetch_rvalid_i),
        .fetch_rdata_i    (fetch_rdata_i),
        .inst_valid_o     (inst_valid_o),
        .inst_o           (inst_o),
        .inst_pc_o        (inst_pc_o),
        .pc_o             (pc_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    // One clock: rising edge updates the DUT, sample point is the next falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Accept the current request this cycle, then return one response with data.
    task automatic fetch_one(input logic [31:0] data);
        fetch_gnt_i = 1'b1;
        tick();
        fetch_gnt_i    = 1'b0;
        fetch_rvalid_i = 1'b1;
        fetch_rdata_i  = data;
        tick();
        fetch_rvalid_i = 1'b0;
    endtask

    initial begin
        rst              = 1'b1;
        stall_i          = 1'b0;
        redirect_valid_i = 1'b0;
        redirect_pc_i    = '0;
        fetch_gnt_i      = 1'b0;
        fetch_rvalid_i   = 1'b0;
        fetch_rdata_i    = '0;
        @(negedge clk);
        @(negedge clk);

        // ---- reset state ----
        check("rst_pc",    pc_o,         32'h0);
        check("rst_req",   fetch_req_o,  32'h0);
        check("rst_valid", inst_valid_o, 32'h0);
        check("rst_inst",  inst_o,       32'h0);
        check("rst_ipc",   inst_pc_o,    32'h0);

        // ---- first fetch: one dead cycle, accept, rvalid two cycles later ----
        rst = 1'b0;
        check("idle_req", fetch_req_o, 32'h0);
        tick();
        check("f0_req",  fetch_req_o,  32'h1);
        check("f0_addr", fetch_addr_o, 32'h0);
        fetch_gnt_i = 1'b1;
        tick();
        fetch_gnt_i = 1'b0;
        check("f0_wait_req", fetch_req_o, 32'h0);
        tick();
        check("f0_wait_valid", inst_valid_o, 32'h0);
        fetch_rvalid_i = 1'b1;
        fetch_rdata_i  = 32'h0000_0013;
        tick();
        fetch_rvalid_i = 1'b0;
        check("f0_valid", inst_valid_o, 32'h1);
        check("f0_inst",  inst_o,       32'h13);
        check("f0_ipc",   inst_pc_o,    32'h0);
        check("f0_pc",    pc_o,         32'h4);

        // ---- stall hold for three cycles ----
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_valid", inst_valid_o, 32'h1);
            check("stall_inst",  inst_o,       32'h13);
            check("stall_ipc",   inst_pc_o,    32'h0);
            check("stall_req",   fetch_req_o,  32'h0);
        end
        stall_i = 1'b0;
        tick();
        check("consume_valid", inst_valid_o, 32'h0);
        check("consume_req",   fetch_req_o,  32'h1);
        check("consume_addr",  fetch_addr_o, 32'h4);

        // ---- sequential fetch at 0x4, consumed -> request at 0x8 ----
        fetch_one(32'h0000_00AA);
        check("f4_ipc", inst_pc_o, 32'h4);
        check("f4_pc",  pc_o,      32'h8);
        tick();
        check("f8_addr", fetch_addr_o, 32'h8);

        // ---- redirect in the same cycle as gnt: 0x8 response dropped ----
        fetch_gnt_i      = 1'b1;
        redirect_valid_i = 1'b1;
        redirect_pc_i    = 32'h40;
        tick();
        fetch_gnt_i      = 1'b0;
        redirect_valid_i = 1'b0;
        check("rg_pc",  pc_o,        32'h40);
        check("rg_req", fetch_req_o, 32'h0);
        fetch_rvalid_i = 1'b1;
        fetch_rdata_i  = 32'hDEAD_0008;
        tick();
        fetch_rvalid_i = 1'b0;
        check("rg_drop_valid", inst_valid_o, 32'h0);
        check("rg_req2",       fetch_req_o,  32'h1);
        check("rg_addr2",      fetch_addr_o, 32'h40);
        fetch_one(32'h0000_0111);
        check("f40_inst", inst_o,    32'h111);
        check("f40_ipc",  inst_pc_o, 32'h40);
        check("f40_pc",   pc_o,      32'h44);

        // ---- redirect from VALID to 0x10 ----
        redirect_valid_i = 1'b1;
        redirect_pc_i    = 32'h10;
        tick();
        redirect_valid_i = 1'b0;
        check("rv_valid", inst_valid_o, 32'h0);
        check("rv_addr",  fetch_addr_o, 32'h10);

        // ---- redirect during WAIT (target 0x203 aligns to 0x200) ----
        fetch_gnt_i = 1'b1;
        tick();
        fetch_gnt_i = 1'b0;
        tick();
        redirect_valid_i = 1'b1;
        redirect_pc_i    = 32'h203;
        tick();
        redirect_valid_i = 1'b0;
        check("rw_pc",  pc_o,        32'h200);
        check("rw_req", fetch_req_o, 32'h0);
        fetch_rvalid_i = 1'b1;
        fetch_rdata_i  = 32'hBAD0_0010;
        tick();
        fetch_rvalid_i = 1'b0;
        check("rw_drop_valid", inst_valid_o, 32'h0);
        check("rw_addr",       fetch_addr_o, 32'h200);
        fetch_one(32'h0000_0222);
        check("f200_inst", inst_o,    32'h222);
        check("f200_ipc",  inst_pc_o, 32'h200);

        // ---- redirect plus stall in VALID: redirect wins ----
        stall_i          = 1'b1;
        redirect_valid_i = 1'b1;
        redirect_pc_i    = 32'h100;
        tick();
        stall_i          = 1'b0;
        redirect_valid_i = 1'b0;
        check("rs_valid", inst_valid_o, 32'h0);
        check("rs_req",   fetch_req_o,  32'h1);
        check("rs_addr",  fetch_addr_o, 32'h100);

        // ---- redirect with rvalid in the same WAIT cycle: dropped, no increment ----
        fetch_gnt_i = 1'b1;
        tick();
        fetch_gnt_i      = 1'b0;
        fetch_rvalid_i   = 1'b1;
        fetch_rdata_i    = 32'h0000_0333;
        redirect_valid_i = 1'b1;
        redirect_pc_i    = 32'h300;
        tick();
        fetch_rvalid_i   = 1'b0;
        redirect_valid_i = 1'b0;
        check("rr_valid", inst_valid_o, 32'h0);
        check("rr_pc",    pc_o,         32'h300);
        check("rr_req",   fetch_req_o,  32'h1);

        // ---- stray rvalid in REQ is ignored ----
        fetch_rvalid_i = 1'b1;
        fetch_rdata_i  = 32'h0000_0999;
        tick();
        fetch_rvalid_i = 1'b0;
        check("stray_valid", inst_valid_o, 32'h0);
        check("stray_req",   fetch_req_o,  32'h1);
        check("stray_inst",  inst_o,       32'h222);

        // ---- redirect in REQ without gnt, then wrap at 0xFFFFFFFC ----
        redirect_valid_i = 1'b1;
        redirect_pc_i    = 32'hFFFF_FFFF;
        tick();
        redirect_valid_i = 1'b0;
        check("wrap_req",  fetch_req_o,  32'h1);
        check("wrap_addr", fetch_addr_o, 32'hFFFF_FFFC);
        fetch_one(32'h0000_0444);
        check("wrap_ipc", inst_pc_o, 32'hFFFF_FFFC);
        check("wrap_pc",  pc_o,      32'h0);
        tick();
        check("wrap_next_addr", fetch_addr_o, 32'h0);

        // ---- async reset mid-WAIT, late rvalid after release ----
        fetch_gnt_i = 1'b1;
        tick();
        fetch_gnt_i = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("arst_inst",  inst_o,       32'h0);
        check("arst_ipc",   inst_pc_o,    32'h0);
        check("arst_pc",    pc_o,         32'h0);
        check("arst_req",   fetch_req_o,  32'h0);
        check("arst_valid", inst_valid_o, 32'h0);
        @(negedge clk);
        rst            = 1'b0;
        fetch_rvalid_i = 1'b1;
        fetch_rdata_i  = 32'h0000_0555;
        tick();
        fetch_rvalid_i = 1'b0;
        check("late_valid", inst_valid_o, 32'h0);
        check("late_inst",  inst_o,       32'h0);
        check("late_req",   fetch_req_o,  32'h1);
        check("late_addr",  fetch_addr_o, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
